// File: rtl/vit_pkg.sv
// Constants shared by the symbol FIFO and the PISO serializer feeding the Viterbi core.
// A word packs eight 2-bit symbol pairs, MSB pair first.
package vit_pkg;
  localparam int SYM_W         = 2;
  localparam int WORD_W        = 16;
  localparam int SYMS_PER_WORD = 8;

  // Pair idx 0 is the first symbol pair sent.
  function automatic logic [SYM_W-1:0] sym_pair(input logic [WORD_W-1:0] word, input int idx);
    return word[WORD_W-1-SYM_W*idx -: SYM_W];
  endfunction
endpackage

// File: rtl/sym_fifo_if.sv
// Write/read/status bundle of the symbol FIFO; master is the host+consumer side, slave is the FIFO.
interface sym_fifo_if #(
  parameter int DEPTH = 16
) ();
  import vit_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clr_i;
  logic              wr_en_i;
  logic [WORD_W-1:0] wr_data_i;
  logic              full_o;
  logic              almost_full_o;
  logic              rd_en_i;
  logic [WORD_W-1:0] rd_data_o;
  logic              empty_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output clr_i, wr_en_i, wr_data_i, rd_en_i,
    input  full_o, almost_full_o, rd_data_o, empty_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  clr_i, wr_en_i, wr_data_i, rd_en_i,
    output full_o, almost_full_o, rd_data_o, empty_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sym_fifo_mem.sv
// Unreset register array: synchronous write port, asynchronous read port.
module sym_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int WORD_W = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WORD_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WORD_W-1:0]        rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sym_fifo.sv
// FWFT symbol-word FIFO: head word on rd_data_o, status one cycle after the accepting edge.
// Writes drop while full and reads are ignored while empty, each latching a sticky error flag.
module sym_fifo
  import vit_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input logic       clk,
  input logic       rst_n,
  sym_fifo_if.slave fif
);
  localparam int ADDR_W = $clog2(DEPTH);
  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t AFULL_C = ptr_t'(AFULL_THRESH);

  ptr_t              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              full, empty, wr_acc, rd_acc;
  logic [WORD_W-1:0] head;

  // Status decodes only from registered pointers, never from the enables.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                  (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign wr_acc = fif.wr_en_i && !full && !fif.clr_i;
  assign rd_acc = fif.rd_en_i && !empty && !fif.clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + ptr_t'(wr_acc);
    rd_ptr_d = rd_ptr_q + ptr_t'(rd_acc);
    ovf_d    = ovf_q | (fif.wr_en_i && full);
    udf_d    = udf_q | (fif.rd_en_i && empty);
    if (fif.clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sym_fifo_mem #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (fif.wr_data_i),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (head)
  );

  assign fif.rd_data_o     = empty ? '0 : head;
  assign fif.empty_o       = empty;
  assign fif.full_o        = full;
  assign fif.count_o       = count;
  assign fif.almost_full_o = (count >= AFULL_C);
  assign fif.overflow_o    = ovf_q;
  assign fif.underflow_o   = udf_q;
endmodule

// File: tb/tb_sym_fifo.sv
// Directed bench for sym_fifo with a queue scoreboard of expected head words and flags.
module tb_sym_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sym_fifo_if #(.DEPTH(DEPTH)) fif ();

  sym_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
  );

  logic [15:0] sb[$];
  int          got_pairs[$];
  bit          cap;
  bit          m_ovf, m_udf;
  int          n_checks, n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_reset();
    chk("rst_count", 32'(fif.count_o), 0);
    chk("rst_empty", 32'(fif.empty_o), 1);
    chk("rst_full", 32'(fif.full_o), 0);
    chk("rst_afull", 32'(fif.almost_full_o), 0);
    chk("rst_rdata", 32'(fif.rd_data_o), 0);
    chk("rst_ovf", 32'(fif.overflow_o), 0);
    chk("rst_udf", 32'(fif.underflow_o), 0);
  endtask

  task automatic chk_status();
    chk("count", 32'(fif.count_o), 32'(sb.size()));
    chk("empty", 32'(fif.empty_o), 32'(sb.size() == 0));
    chk("full", 32'(fif.full_o), 32'(sb.size() == DEPTH));
    chk("afull", 32'(fif.almost_full_o), 32'(sb.size() >= DEPTH - 2));
    chk("ovf", 32'(fif.overflow_o), 32'(m_ovf));
    chk("udf", 32'(fif.underflow_o), 32'(m_udf));
    chk("head", 32'(fif.rd_data_o), (sb.size() == 0) ? 32'h0 : 32'(sb[0]));
  endtask

  // Called at 1 time unit after a rising edge; drives one cycle of stimulus.
  task automatic cyc(input logic wr, input logic [15:0] d, input logic rd, input logic clr);
    bit f, e;
    fif.wr_en_i   = wr;
    fif.wr_data_i = d;
    fif.rd_en_i   = rd;
    fif.clr_i     = clr;
    #1;
    if (rd && sb.size() > 0) begin
      chk("pop_data", 32'(fif.rd_data_o), 32'(sb[0]));
      if (cap) for (int k = 0; k < 8; k++) got_pairs.push_back(int'((fif.rd_data_o >> (14 - 2 * k)) & 16'h3));
    end
    @(posedge clk);
    if (clr) begin
      sb.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      f = (sb.size() == DEPTH);
      e = (sb.size() == 0);
      if (wr && f) m_ovf = 1;
      if (rd && e) m_udf = 1;
      if (rd && !e) void'(sb.pop_front());
      if (wr && !f) sb.push_back(d);
    end
    #1;
    chk_status();
  endtask

  initial begin
    int exp_pairs[24] = '{3,2,1,0,0,1,2,3, 0,1,0,2,0,3,1,0, 3,3,3,3,3,3,3,3};
    logic [15:0] words[3] = '{16'hE41B, 16'h1234, 16'hFFFF};
    n_checks = 0;
    n_pass   = 0;
    cap      = 0;
    m_ovf    = 0;
    m_udf    = 0;
    rst_n         = 1'b0;
    fif.clr_i     = 1'b0;
    fif.wr_en_i   = 1'b0;
    fif.wr_data_i = '0;
    fif.rd_en_i   = 1'b0;

    // Reset and idle
    #3;
    chk_reset();
    @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    repeat (20) cyc(0, 16'h0, 0, 0);

    // Fill, then drain at PISO cadence
    for (int i = 0; i < 3; i++) cyc(1, words[i], 0, 0);
    cap = 1;
    for (int p = 0; p < 3; p++) begin
      cyc(0, 16'h0, 1, 0);
      repeat (9) cyc(0, 16'h0, 0, 0);
    end
    cap = 0;
    chk("pair_count", 32'(got_pairs.size()), 24);
    for (int k = 0; k < 24 && k < got_pairs.size(); k++) chk($sformatf("pair%0d", k), 32'(got_pairs[k]), 32'(exp_pairs[k]));
    chk("piso_udf", 32'(fif.underflow_o), 0);

    // Full boundary and dropped 17th write
    for (int i = 0; i < DEPTH; i++) cyc(1, 16'hA000 + 16'(i * 16'h0111), 0, 0);
    chk("full_count", 32'(fif.count_o), DEPTH);
    chk("full_flag", 32'(fif.full_o), 1);
    cyc(1, 16'hDEAD, 0, 0);
    chk("dead_ovf", 32'(fif.overflow_o), 1);
    repeat (DEPTH) cyc(0, 16'h0, 1, 0);
    cyc(0, 16'h0, 0, 1);

    // Simultaneous read/write at count 5, then at full
    for (int i = 0; i < 5; i++) cyc(1, 16'h5000 + 16'(i), 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 16'h5100 + 16'(i), 1, 0);
    chk("rw_count", 32'(fif.count_o), 5);
    for (int i = 0; i < 11; i++) cyc(1, 16'h5200 + 16'(i), 0, 0);
    cyc(1, 16'hBEEF, 1, 0);
    chk("rwfull_count", 32'(fif.count_o), DEPTH - 1);
    chk("rwfull_ovf", 32'(fif.overflow_o), 1);
    repeat (DEPTH - 1) cyc(0, 16'h0, 1, 0);
    cyc(0, 16'h0, 0, 1);

    // Wrap-around streaming, then read while empty
    for (int i = 0; i < 3 * DEPTH; i++) cyc(1, 16'(i), (i > 0), 0);
    cyc(0, 16'h0, 1, 0);
    cyc(0, 16'h0, 1, 0);
    chk("udf_set", 32'(fif.underflow_o), 1);
    chk("udf_rdata", 32'(fif.rd_data_o), 0);

    // Flush at count 7 with a same-cycle write
    for (int i = 0; i < 7; i++) cyc(1, 16'h7000 + 16'(i), 0, 0);
    cyc(1, 16'h7777, 0, 1);
    chk("clr_empty", 32'(fif.empty_o), 1);
    chk("clr_count", 32'(fif.count_o), 0);
    chk("clr_udf", 32'(fif.underflow_o), 0);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 5; i++) cyc(1, 16'h9000 + 16'(i), 0, 0);
    cyc(0, 16'h0, 1, 0);
    cyc(0, 16'h0, 1, 0);
    fif.rd_en_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset();
    sb.delete();
    m_ovf = 0;
    m_udf = 0;
    fif.rd_en_i = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 16'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sym_fifo.md
# sym_fifo

First-word-fall-through (FWFT) synchronous FIFO that buffers 16-bit packed symbol words (eight 2-bit soft/hard symbol pairs, MSB pair first) from the host write path. It sits directly upstream of the PISO serializer that feeds the Viterbi core. The read side is shaped for that consumer: `rd_data_o` always shows the head word, so a one-cycle `rd_en_i` pulse is sampled by the consumer on the same edge that pops the word. It also provides occupancy, almost-full back-pressure, a synchronous flush and sticky error flags.

## Interface
- `DEPTH`, default 16: number of 16-bit entries; must be a power of two and at least 4.
- `AFULL_THRESH`, default `DEPTH-2`: `almost_full_o` is asserted when `count_o >= AFULL_THRESH`.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `clr_i` in, 1: synchronous flush; empties the FIFO and clears the error flags.
- `wr_en_i` in, 1: write request.
- `wr_data_i` in, 16: word to write; bits [15:14] are the first symbol pair.
- `full_o` out, 1: FIFO holds `DEPTH` words.
- `almost_full_o` out, 1: occupancy is at or above `AFULL_THRESH`.
- `rd_en_i` in, 1: pop request from the PISO (its `fifo_rd_en_o`).
- `rd_data_o` out, 16: head word (FWFT); drives the PISO `fifo_data_i`.
- `empty_o` out, 1: FIFO holds no words; drives the PISO `fifo_empty_i`.
- `count_o` out, $clog2(DEPTH)+1: current occupancy, 0..`DEPTH`.
- `overflow_o` out, 1: sticky; set by a write attempted while full.
- `underflow_o` out, 1: sticky; set by a read attempted while empty.

## Operation
- **Storage:** register array of `DEPTH`×16 bits.
- **Pointers:** `wr_ptr` and `rd_ptr` are `ADDR_W+1` bits wide, with `ADDR_W = $clog2(DEPTH)`. The MSB is a wrap bit and both pointers wrap modulo `2*DEPTH`.
- **Occupancy:** `count_o = wr_ptr - rd_ptr`, computed modulo `2^(ADDR_W+1)`.
  - `empty_o = (wr_ptr == rd_ptr)`.
  - `full_o` is true when the address bits are equal and the wrap bits differ.
  - All status outputs decode from registered pointers only; there is no combinational path from `wr_en_i` or `rd_en_i` to any output.
- **Write acceptance:** a write is accepted iff `wr_en_i && !full_o`. On acceptance, `mem[wr_ptr[ADDR_W-1:0]] <= wr_data_i` and `wr_ptr` increments.
- **Read acceptance:** a read is accepted iff `rd_en_i && !empty_o`; `rd_ptr` increments.
- **Read data:** `rd_data_o = mem[rd_ptr[ADDR_W-1:0]]` when not empty, otherwise `16'h0000`.
- **Simultaneous accepted read and write:** both pointers advance and `count_o` is unchanged.
- **Full with simultaneous read:** the write is rejected, because acceptance uses the registered `full_o`. Overflow is flagged and the read is accepted.
- **Empty with simultaneous write:** the read is rejected and underflow is flagged. The write is accepted, and the new word appears on `rd_data_o` in the next cycle.
- **Error flags:** `overflow_o` sets on `wr_en_i && full_o`; `underflow_o` sets on `rd_en_i && empty_o`. Both hold until `clr_i` or reset.
- **Flush (`clr_i`):** zeroes both pointers and both error flags, and overrides any same-cycle write or read. The memory contents are not cleared.
- **Reset:** `rst_n` low asynchronously zeroes the pointers and flags; the memory is not reset. While in reset: `empty_o`=1, `full_o`=0, `almost_full_o`=0, `count_o`=0, `rd_data_o`=0, `overflow_o`=0, `underflow_o`=0.
- **Reset mid-operation:** all stored words are discarded. The PISO is reset by the same `rst_n`.

## Timing
- **Write to read visibility:** a write accepted at edge T deasserts `empty_o` and makes `rd_data_o` valid in the cycle after edge T.
- **Read:** a pop is accepted at edge T when `rd_en_i` is high in the preceding cycle. The consumer samples `rd_data_o` at that same edge T, and the next head word is presented after edge T.
- **PISO cadence:** the PISO holds `rd_en_i` high for one cycle per 10-cycle word. The FIFO must tolerate back-to-back `rd_en_i` from any other consumer at one word per cycle.
- **Status latency:** `full_o`, `almost_full_o` and `count_o` update one cycle after the accepting edge.
- **Throughput:** one write and one read per cycle sustained.

## Structure
- **Shared package `vit_pkg`** holds the constants shared with `piso`:
  - `SYM_W = 2`
  - `WORD_W = 16`
  - `SYMS_PER_WORD = 8`
- **Sub-module `sym_fifo_mem`:** a plain register array with a synchronous write port and an asynchronous read port, parameterised on `DEPTH` and `WORD_W`. It has no reset.
- **Top level:** pointer, flag and occupancy logic live in `sym_fifo`.

## Test plan
- **Reset/idle:** with `rst_n` low, all outputs are at their reset values. Release reset with no traffic: `empty_o`=1, `count_o`=0 and `rd_data_o`=0 for 20 cycles.
- **Fill/drain with PISO attached:** write `16'hE41B`, `16'h1234`, `16'hFFFF`. The PISO emits the pairs 3,2,1,0,0,1,2,3, then the symbols of `1234` and `FFFF` in order. `empty_o` reasserts after the third pop and `underflow_o` stays 0.
- **Full boundary:**
  - Write `DEPTH` words: `full_o`=1 and `count_o`=`DEPTH`; `almost_full_o`=1 from `count_o`=14.
  - A 17th write of `16'hDEAD` is dropped and sets `overflow_o`=1.
  - Draining returns the first 16 words unchanged, and `DEAD` never appears.
- **Simultaneous read and write:**
  - At `count_o`=5, assert `wr_en_i` and `rd_en_i` for 8 cycles: `count_o` stays 5 and order is preserved.
  - When full, do the same in one cycle: the read is accepted, the write is dropped and `overflow_o`=1.
- **Wrap-around and underflow:**
  - Stream 3×`DEPTH` sequential words (0x0000 upward) at one per cycle with a concurrent drain; all words are read back in order, exercising pointer wrap.
  - `rd_en_i` while empty sets `underflow_o`, and `rd_data_o` stays 0.
- **Flush and async reset:**
  - `clr_i` at `count_o`=7 with a same-cycle write gives `empty_o`=1, `count_o`=0 and both flags 0 in the next cycle.
  - Asserting `rst_n` low mid-drain returns all outputs to their reset values immediately, without waiting for a clock edge.
